// File: rtl/branch_trace_driver_if.sv
// Bundle between the branch trace driver, its trace memory, the predictor under
// test and the run controller.
interface branch_trace_driver_if #(
    parameter int unsigned IP_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH = 16
) ();
    logic                 start;
    logic [CNT_WIDTH-1:0] trace_count;
    logic [CNT_WIDTH-1:0] trace_addr;
    logic [IP_WIDTH-1:0]  trace_ip;
    logic                 trace_taken;
    logic [IP_WIDTH-1:0]  pred_ip;
    logic                 pred_taken;
    logic                 pred_prediction;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] miss_count;

    modport master (
        input  start, trace_count, trace_ip, trace_taken, pred_prediction,
        output trace_addr, pred_ip, pred_taken, busy, done, hit_count, miss_count
    );

    modport slave (
        output start, trace_count, trace_ip, trace_taken, pred_prediction,
        input  trace_addr, pred_ip, pred_taken, busy, done, hit_count, miss_count
    );
endinterface

// File: rtl/branch_trace_driver.sv
// Replays a branch trace from memory into a predictor, feeding back each outcome
// one cycle late and scoring predictions as hits or misses.
module branch_trace_driver #(
    parameter int unsigned IP_WIDTH  = 64,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    branch_trace_driver_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] addr_q, addr_d;
    logic [IP_WIDTH-1:0]  ip_q, ip_d;
    logic                 taken_q, taken_d;
    logic [CNT_WIDTH-1:0] hit_q, hit_d;
    logic [CNT_WIDTH-1:0] miss_q, miss_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
            addr_q  <= '0;
            ip_q    <= '0;
            taken_q <= 1'b0;
            hit_q   <= '0;
            miss_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            ip_q    <= ip_d;
            taken_q <= taken_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        ip_d    = ip_q;
        taken_d = taken_q;
        hit_d   = hit_q;
        miss_d  = miss_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    count_d = bus.trace_count;
                    addr_d  = '0;
                    hit_d   = '0;
                    miss_d  = '0;
                    if (bus.trace_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        // No outcome is owed to the predictor in the first RUN cycle
                        taken_d = 1'b0;
                    end
                end
            end
            RUN: begin
                addr_d  = addr_q + CNT_WIDTH'(1);
                ip_d    = bus.trace_ip;
                taken_d = bus.trace_taken;
                if (bus.pred_prediction == bus.trace_taken) begin
                    hit_d = hit_q + CNT_WIDTH'(1);
                end else begin
                    miss_d = miss_q + CNT_WIDTH'(1);
                end
                if (addr_q == count_q - CNT_WIDTH'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
        endcase
    end

    assign busy_d = (state_d == RUN) || (state_d == DRAIN);
    assign done_d = (state_d == DONE);

    // Live memory address during RUN; otherwise replay or hold the last one
    assign bus.pred_ip    = (state_q == RUN) ? bus.trace_ip : ip_q;
    assign bus.pred_taken = taken_q;
    assign bus.trace_addr = addr_q;
    assign bus.hit_count  = hit_q;
    assign bus.miss_count = miss_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_branch_trace_driver.sv
// Directed, table-driven bench for branch_trace_driver with a trace memory model
// and a 256-entry 2-bit predictor model.
module tb_branch_trace_driver;

    localparam int unsigned IPW = 64;
    localparam int unsigned CW  = 16;

    typedef struct {
        int unsigned n;
        logic [15:0] taken;
        logic [63:0] ip_base;
        logic [63:0] ip_step;
        logic        use_bp;
        logic        pred;
        logic        poke;
        int unsigned hit;
        int unsigned miss;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    branch_trace_driver_if #(.IP_WIDTH(IPW), .CNT_WIDTH(CW)) bus ();

    branch_trace_driver #(.IP_WIDTH(IPW), .CNT_WIDTH(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Trace memory with combinational read
    logic [IPW-1:0] mem_ip [32];
    logic           mem_taken [32];
    assign bus.trace_ip    = mem_ip[bus.trace_addr[4:0]];
    assign bus.trace_taken = mem_taken[bus.trace_addr[4:0]];

    // 2-bit saturating predictor, indexed by ip[7:0], with write bypass
    logic           use_bp = 1'b0;
    logic           pred_const = 1'b1;
    logic           bp_clear = 1'b0;
    logic [1:0]     bp_tab [256];
    logic           bp_upd = 1'b0;
    logic [IPW-1:0] bp_last_ip = '0;
    logic [1:0]     bp_cur;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'b11) ? c : c + 2'b01;
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

    always_comb begin
        bp_cur = bp_tab[bus.pred_ip[7:0]];
        if (bp_upd && bus.busy && (bp_last_ip[7:0] == bus.pred_ip[7:0]))
            bp_cur = sat(bp_cur, bus.pred_taken);
    end

    always @(posedge clk) begin
        if (bp_clear) begin
            for (int i = 0; i < 256; i++) bp_tab[i] <= 2'b01;
            bp_upd <= 1'b0;
        end else begin
            if (bp_upd && bus.busy)
                bp_tab[bp_last_ip[7:0]] <= sat(bp_tab[bp_last_ip[7:0]], bus.pred_taken);
            bp_upd     <= bus.busy;
            bp_last_ip <= bus.pred_ip;
        end
    end

    assign bus.pred_prediction = use_bp ? bp_cur[1] : pred_const;

    logic [IPW-1:0] hold_ip = '0;
    logic           hold_tk = 1'b0;
    vec_t           vecs [8];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, 64'(bus.trace_addr), 64'd0);
        chk({tag, "_pip"},  bus.pred_ip, 64'd0);
        chk({tag, "_ptk"},  64'(bus.pred_taken), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_hit"},  64'(bus.hit_count), 64'd0);
        chk({tag, "_miss"}, 64'(bus.miss_count), 64'd0);
    endtask

    // Start one run from IDLE/DONE and check it cycle by cycle until DONE
    task automatic run_vec(input int idx, input vec_t v);
        logic [63:0] exp_ip;
        for (int i = 0; i < 32; i++) begin
            mem_ip[i]    = v.ip_base + v.ip_step * 64'(i);
            mem_taken[i] = (i < 16) ? v.taken[i] : 1'b0;
        end
        use_bp     = v.use_bp;
        pred_const = v.pred;
        if (v.use_bp) begin
            bp_clear = 1'b1;
            @(posedge clk); #1;
            bp_clear = 1'b0;
        end
        bus.trace_count = CW'(v.n);
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start       = 1'b0;
        bus.trace_count = CW'($urandom);
        if (v.n == 0) begin
            chk($sformatf("v%0d_zero_done", idx), 64'(bus.done), 64'd1);
            chk($sformatf("v%0d_zero_busy", idx), 64'(bus.busy), 64'd0);
            chk($sformatf("v%0d_zero_hit", idx),  64'(bus.hit_count), 64'd0);
            chk($sformatf("v%0d_zero_miss", idx), 64'(bus.miss_count), 64'd0);
            chk($sformatf("v%0d_zero_pip", idx),  bus.pred_ip, hold_ip);
            chk($sformatf("v%0d_zero_ptk", idx),  64'(bus.pred_taken), 64'(hold_tk));
            @(posedge clk); #1;
            chk($sformatf("v%0d_zero_busy2", idx), 64'(bus.busy), 64'd0);
            chk($sformatf("v%0d_zero_done2", idx), 64'(bus.done), 64'd1);
        end else begin
            for (int k = 0; k < int'(v.n); k++) begin
                exp_ip = v.ip_base + v.ip_step * 64'(k);
                chk($sformatf("v%0d_addr%0d", idx, k), 64'(bus.trace_addr), 64'(k));
                chk($sformatf("v%0d_busy%0d", idx, k), 64'(bus.busy), 64'd1);
                chk($sformatf("v%0d_done%0d", idx, k), 64'(bus.done), 64'd0);
                chk($sformatf("v%0d_pip%0d", idx, k),  bus.pred_ip, exp_ip);
                chk($sformatf("v%0d_ptk%0d", idx, k),  64'(bus.pred_taken),
                    (k == 0) ? 64'd0 : 64'(v.taken[k-1]));
                if (k == 0) begin
                    chk($sformatf("v%0d_hit_clr", idx),  64'(bus.hit_count), 64'd0);
                    chk($sformatf("v%0d_miss_clr", idx), 64'(bus.miss_count), 64'd0);
                end
                bus.start       = v.poke && (k < 2);
                bus.trace_count = CW'($urandom);
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
            exp_ip = v.ip_base + v.ip_step * 64'(v.n - 1);
            chk($sformatf("v%0d_drain_busy", idx), 64'(bus.busy), 64'd1);
            chk($sformatf("v%0d_drain_done", idx), 64'(bus.done), 64'd0);
            chk($sformatf("v%0d_drain_pip", idx),  bus.pred_ip, exp_ip);
            chk($sformatf("v%0d_drain_ptk", idx),  64'(bus.pred_taken), 64'(v.taken[v.n-1]));
            chk($sformatf("v%0d_drain_hit", idx),  64'(bus.hit_count), 64'(v.hit));
            chk($sformatf("v%0d_drain_miss", idx), 64'(bus.miss_count), 64'(v.miss));
            @(posedge clk); #1;
            chk($sformatf("v%0d_done", idx),      64'(bus.done), 64'd1);
            chk($sformatf("v%0d_done_busy", idx), 64'(bus.busy), 64'd0);
            chk($sformatf("v%0d_hit", idx),       64'(bus.hit_count), 64'(v.hit));
            chk($sformatf("v%0d_miss", idx),      64'(bus.miss_count), 64'(v.miss));
            chk($sformatf("v%0d_hold_pip", idx),  bus.pred_ip, exp_ip);
            chk($sformatf("v%0d_hold_ptk", idx),  64'(bus.pred_taken), 64'(v.taken[v.n-1]));
            hold_ip = exp_ip;
            hold_tk = v.taken[v.n-1];
        end
    endtask

    initial begin
        //           n  taken    ip_base                 step       bp    pred  poke  hit miss
        vecs[0] = '{4, 16'h000D, 64'h1000,               64'h4,     1'b0, 1'b1, 1'b0, 3, 1};
        vecs[1] = '{3, 16'h0005, 64'h100,                64'h104,   1'b0, 1'b1, 1'b0, 2, 1};
        vecs[2] = '{5, 16'h0000, 64'h2000,               64'h8,     1'b0, 1'b0, 1'b0, 5, 0};
        vecs[3] = '{1, 16'h0001, 64'hDEAD_BEEF_0000_0010, 64'h0,    1'b0, 1'b0, 1'b0, 0, 1};
        vecs[4] = '{6, 16'h000B, 64'h4000,               64'h20,    1'b0, 1'b0, 1'b0, 3, 3};
        vecs[5] = '{0, 16'h0000, 64'h0,                  64'h0,     1'b0, 1'b1, 1'b0, 0, 0};
        vecs[6] = '{8, 16'h00FF, 64'h40,                 64'h0,     1'b1, 1'b0, 1'b0, 7, 1};
        vecs[7] = '{4, 16'h000D, 64'h3000,               64'h10,    1'b0, 1'b1, 1'b1, 3, 1};

        bus.start       = 1'b0;
        bus.trace_count = '0;
        for (int i = 0; i < 32; i++) begin
            mem_ip[i]    = '0;
            mem_taken[i] = 1'b0;
        end

        #2 reset_n = 1'b0;
        #6 chk_all_zero("reset");
        #5 reset_n = 1'b1;

        // First start lands on the first edge after reset release
        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset asserted in the middle of a run
        for (int i = 0; i < 32; i++) begin
            mem_ip[i]    = 64'h500 + 64'(i);
            mem_taken[i] = 1'b1;
        end
        pred_const      = 1'b1;
        use_bp          = 1'b0;
        bus.trace_count = CW'(6);
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midrun_addr", 64'(bus.trace_addr), 64'd2);
        chk("midrun_busy", 64'(bus.busy), 64'd1);
        reset_n = 1'b0;
        #1 chk_all_zero("midrst");
        @(posedge clk); #1;
        chk_all_zero("midrst_hold");
        reset_n = 1'b1;
        hold_ip = '0;
        hold_tk = 1'b0;
        run_vec(8, vecs[0]);
        run_vec(9, vecs[5]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
